// File: rtl/matrix_mac_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mac_datapath_if
// Purpose  : Bundles the control-FSM strobes, A/B operands, entry_count
//            feedback and the C result valid/ready handshake of the 2x2
//            matrix-multiply datapath.
// Ports    : master - control/producer side (drives strobes, operands,
//                     c_ready; observes entry_count, c_flat, c_valid, overrun)
//            slave  - datapath side (the opposite directions)
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_mac_datapath_if #(
  parameter int DATA_W = 8
);
  localparam int SUM_W = 2 * DATA_W + 1;

  logic                  multiply_matrix;
  logic                  load_matrix;
  logic                  add;
  logic                  done;
  logic [4*DATA_W-1:0]   a_flat;
  logic [4*DATA_W-1:0]   b_flat;
  logic [3:0]            entry_count;
  logic [4*SUM_W-1:0]    c_flat;
  logic                  c_valid;
  logic                  c_ready;
  logic                  overrun;

  modport master (
    output multiply_matrix, load_matrix, add, done, a_flat, b_flat, c_ready,
    input  entry_count, c_flat, c_valid, overrun
  );

  modport slave (
    input  multiply_matrix, load_matrix, add, done, a_flat, b_flat, c_ready,
    output entry_count, c_flat, c_valid, overrun
  );
endinterface
`default_nettype wire

// File: rtl/matrix_mac_datapath.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mac_datapath
// Purpose  : 2x2 x 2x2 unsigned matrix-multiply datapath under control of an
//            external FSM. One scalar product per Multiply cycle (8 total),
//            pairwise sums on add, result registered on done and offered
//            downstream on a valid/ready handshake.
// Ports    : clock  - rising-edge clock
//            reset  - asynchronous, active-high, clears every register
//            bus    - matrix_mac_datapath_if.slave (strobes, a_flat/b_flat,
//                     entry_count, c_flat/c_valid/c_ready, overrun)
// Revision : 1.0 - initial release
// ============================================================================
module matrix_mac_datapath #(
  parameter int DATA_W = 8
) (
  input  wire logic              clock,
  input  wire logic              reset,
  matrix_mac_datapath_if.slave   bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 1;

  logic                 w_step;
  logic [2:0]           r_k;
  logic [4*DATA_W-1:0]  r_a_flat;
  logic [4*DATA_W-1:0]  r_b_flat;
  logic [PROD_W-1:0]    r_p [8];
  logic [SUM_W-1:0]     r_s [4];
  logic [SUM_W-1:0]     w_sum [4];
  logic [4*SUM_W-1:0]   w_s_flat;
  logic [4*SUM_W-1:0]   r_c_flat;
  logic                 r_c_valid;
  logic                 r_overrun;

  logic [4*DATA_W-1:0]  w_a_src;
  logic [4*DATA_W-1:0]  w_b_src;
  logic [DATA_W-1:0]    w_a_el;
  logic [DATA_W-1:0]    w_b_el;
  logic [PROD_W-1:0]    w_prod;

  assign w_step = bus.multiply_matrix & bus.load_matrix;

  // Product k computes A[i][m]*B[m][j] with i=k[2], j=k[1], m=k[0].
  // On k==0 the operands are not yet latched, so the live inputs are used.
  always_comb begin
    w_a_src = (r_k == 3'd0) ? bus.a_flat : r_a_flat;
    w_b_src = (r_k == 3'd0) ? bus.b_flat : r_b_flat;
    w_a_el  = w_a_src[DATA_W*int'({r_k[2], r_k[0]}) +: DATA_W];
    w_b_el  = w_b_src[DATA_W*int'({r_k[0], r_k[1]}) +: DATA_W];
    w_prod  = PROD_W'(w_a_el) * PROD_W'(w_b_el);
  end

  // Counter, operand capture and product registers. The 3-bit counter wraps
  // from 7 to 0 naturally while step is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_k      <= 3'd0;
      r_a_flat <= '0;
      r_b_flat <= '0;
      for (int n = 0; n < 8; n++) r_p[n] <= '0;
    end else begin
      if (w_step) begin
        r_k      <= r_k + 3'd1;
        r_p[r_k] <= w_prod;
        if (r_k == 3'd0) begin
          r_a_flat <= bus.a_flat;
          r_b_flat <= bus.b_flat;
        end
      end else begin
        r_k <= 3'd0;
      end
    end
  end

  generate
    for (genvar n = 0; n < 4; n++) begin : g_sum
      assign w_sum[n] = SUM_W'(r_p[2*n]) + SUM_W'(r_p[2*n+1]);
      assign w_s_flat[SUM_W*n +: SUM_W] = r_s[n];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) r_s[n] <= '0;
    end else if (bus.add) begin
      for (int n = 0; n < 4; n++) r_s[n] <= w_sum[n];
    end
  end

  // Result register and handshake. A done while a result is still pending
  // and not being accepted this cycle overwrites it and flags overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_c_flat  <= '0;
      r_c_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else if (bus.done) begin
      r_c_flat  <= w_s_flat;
      r_c_valid <= 1'b1;
      if (r_c_valid && !bus.c_ready) r_overrun <= 1'b1;
    end else if (r_c_valid && bus.c_ready) begin
      r_c_valid <= 1'b0;
    end
  end

  assign bus.entry_count = {1'b0, r_k};
  assign bus.c_flat      = r_c_flat;
  assign bus.c_valid     = r_c_valid;
  assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mac_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_mac_datapath
// Purpose  : Self-checking bench for matrix_mac_datapath. Stimulus plays the
//            role of the control FSM; expected C matrices are computed with
//            plain matrix arithmetic and queued, and a monitor pops and
//            compares on every completed handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_mac_datapath;
  localparam int DATA_W = 8;
  localparam int SUM_W  = 2 * DATA_W + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  matrix_mac_datapath_if #(.DATA_W(DATA_W)) bus ();
  matrix_mac_datapath #(.DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [4*SUM_W-1:0] exp_q [$];
  logic               exp_overrun;

  int unsigned a1[4], b1[4], a2[4], b2[4], ar[4], br[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Element index 2*row+col for both A and B.
  function automatic logic [4*SUM_W-1:0] ref_mul(input int unsigned a[4], input int unsigned b[4]);
    logic [4*SUM_W-1:0] r;
    int unsigned acc;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int m = 0; m < 2; m++) acc += a[2*i+m] * b[2*m+j];
        r[SUM_W*(2*i+j) +: SUM_W] = acc[SUM_W-1:0];
      end
    return r;
  endfunction

  function automatic logic [4*DATA_W-1:0] pack_m(input int unsigned a[4]);
    logic [4*DATA_W-1:0] r;
    logic [31:0] e;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      e = a[n];
      r[DATA_W*n +: DATA_W] = e[DATA_W-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: ready always 1, 1: always 0, 2: random, 3: ready only on done cycle
  task automatic set_ready(input int mode, input bit is_done);
    case (mode)
      0:       bus.c_ready = 1'b1;
      1:       bus.c_ready = 1'b0;
      2:       bus.c_ready = 1'($urandom_range(1, 0));
      default: bus.c_ready = is_done;
    endcase
  endtask

  task automatic idle_strobes();
    bus.multiply_matrix = 1'b0;
    bus.load_matrix     = 1'b0;
    bus.add             = 1'b0;
    bus.done            = 1'b0;
  endtask

  task automatic run_op(input int unsigned a[4], input int unsigned b[4],
                        input int mode, input bit zero_after);
    logic [4*SUM_W-1:0] e;
    e = ref_mul(a, b);
    bus.a_flat = pack_m(a);
    bus.b_flat = pack_m(b);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("entry_count[%0d]", k), 128'(bus.entry_count), 128'(k));
      bus.multiply_matrix = 1'b1;
      bus.load_matrix     = 1'b1;
      bus.add             = 1'b0;
      bus.done            = 1'b0;
      set_ready(mode, 1'b0);
      tick();
      if (zero_after && k == 0) begin
        bus.a_flat = '0;
        bus.b_flat = '0;
      end
    end
    chk("entry_count_wrap", 128'(bus.entry_count), 128'(0));
    idle_strobes();
    bus.add = 1'b1;
    set_ready(mode, 1'b0);
    tick();
    idle_strobes();
    bus.done = 1'b1;
    set_ready(mode, 1'b1);
    // A still-pending result that is not accepted this cycle gets replaced.
    if (exp_q.size() != 0 && !bus.c_ready) begin
      void'(exp_q.pop_back());
      exp_overrun = 1'b1;
    end
    exp_q.push_back(e);
    tick();
    idle_strobes();
    set_ready(mode, 1'b0);
  endtask

  // Monitor: every accepted result must match the oldest expected one.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.c_valid === 1'b1 && bus.c_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0h, expected no valid", bus.c_flat);
      end else begin
        chk("c_flat", 128'(bus.c_flat), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*SUM_W-1:0] e1, e2;
    int budget;
    a1 = '{1, 2, 3, 4};
    b1 = '{5, 6, 7, 8};
    a2 = '{9, 0, 11, 200};
    b2 = '{13, 250, 1, 7};
    exp_overrun = 1'b0;
    reset = 1'b1;
    idle_strobes();
    bus.a_flat  = '0;
    bus.b_flat  = '0;
    bus.c_ready = 1'b0;
    tick();
    tick();
    chk("reset_entry_count", 128'(bus.entry_count), 128'(0));
    chk("reset_c_valid", 128'(bus.c_valid), 128'(0));
    chk("reset_overrun", 128'(bus.overrun), 128'(0));
    chk("reset_c_flat", 128'(bus.c_flat), 128'(0));
    reset = 1'b0;
    tick();

    // Scenario 1: basic product, single-cycle valid.
    run_op(a1, b1, 0, 1'b0);
    chk("s1_valid_hi", 128'(bus.c_valid), 128'(1));
    bus.c_ready = 1'b1;
    tick();
    chk("s1_valid_lo", 128'(bus.c_valid), 128'(0));

    // Scenario 2: full-scale operands.
    for (int n = 0; n < 4; n++) begin ar[n] = 255; br[n] = 255; end
    run_op(ar, br, 0, 1'b0);
    tick();

    // Scenario 3: operands removed after the first step cycle.
    run_op(a1, b1, 0, 1'b1);
    tick();

    // Scenario 5: done coincides with acceptance of a pending result.
    run_op(a2, b2, 1, 1'b0);
    tick();
    run_op(a1, b1, 3, 1'b0);
    chk("s5_valid_stays", 128'(bus.c_valid), 128'(1));
    chk("s5_no_overrun", 128'(bus.overrun), 128'(0));
    bus.c_ready = 1'b1;
    tick();
    bus.c_ready = 1'b0;

    // Scenario 4: back-to-back with no acceptance -> overwrite and overrun.
    e1 = ref_mul(a2, b2);
    e2 = ref_mul(a1, b1);
    run_op(a2, b2, 1, 1'b0);
    tick();
    chk("s4_hold_first", 128'(bus.c_flat), 128'(e1));
    run_op(a1, b1, 1, 1'b0);
    chk("s4_second", 128'(bus.c_flat), 128'(e2));
    chk("s4_overrun", 128'(bus.overrun), 128'(exp_overrun));
    chk("s4_overrun_set", 128'(bus.overrun), 128'(1));
    bus.c_ready = 1'b1;
    tick();

    // Scenario 6: reset in the middle of the Multiply phase.
    bus.a_flat = pack_m(a2);
    bus.b_flat = pack_m(b2);
    bus.multiply_matrix = 1'b1;
    bus.load_matrix     = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("s6_k4", 128'(bus.entry_count), 128'(4));
    reset = 1'b1;
    #1;
    chk("s6_rst_entry_count", 128'(bus.entry_count), 128'(0));
    chk("s6_rst_c_valid", 128'(bus.c_valid), 128'(0));
    chk("s6_rst_overrun", 128'(bus.overrun), 128'(0));
    exp_q.delete();
    exp_overrun = 1'b0;
    idle_strobes();
    tick();
    reset = 1'b0;
    tick();
    run_op(a1, b1, 0, 1'b0);
    tick();

    // Randomized operations with random backpressure.
    for (int t = 0; t < 20; t++) begin
      for (int n = 0; n < 4; n++) begin
        ar[n] = $urandom_range(255, 0);
        br[n] = $urandom_range(255, 0);
      end
      run_op(ar, br, 2, 1'($urandom_range(1, 0)));
      for (int w = $urandom_range(2, 0); w > 0; w--) begin
        set_ready(2, 1'b0);
        tick();
      end
    end
    chk("rand_overrun", 128'(bus.overrun), 128'(exp_overrun));

    bus.c_ready = 1'b1;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    tick();
    chk("final_c_valid", 128'(bus.c_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
